dispatch_ctrl: RTL and testbench
================================

DISPATCH_CTRL -- requirements
Module: dispatch_ctrl

Interface
REQ-001 SHALL have ports: clk_in  in  1  system clock, rising edge.
REQ-002 SHALL have ports: rst_n_in  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: rdy_in  in  1  global enable; low freezes all state.
REQ-004 SHALL have ports: flush_in  in  1  mispredict clear.
REQ-005 SHALL have ports: iq_valid_in  in  1 / iq_inst_in  in  32 / iq_pc_in  in  32 / iq_pred_taken_in  in  1  instruction-queue head.
REQ-006 SHALL have ports: iq_ready_out  out  1  accept strobe toward the instruction queue.
REQ-007 SHALL have ports: rob_full_in, rs_full_in, lsb_full_in  in  1 each  resource-full flags.
REQ-008 SHALL have ports: issue_valid_out  out  1 / issue_to_lsb_out  out  1 / issue_to_rs_out  out  1.
REQ-009 SHALL have ports: issue_opt_out  out  7 / issue_rd_out, issue_rs1_out, issue_rs2_out  out  5 each.
REQ-010 SHALL have ports: issue_imm_out  out  32 / issue_pc_out  out  32 / issue_is_btype_out  out  1 / issue_pred_taken_out  out  1.
REQ-011 SHALL have ports, only with DISPATCH_PERF_EN: perf_issued_out  out  32 / perf_stall_out  out  32.

Function
REQ-012 SHALL implement a two-state FSM: EMPTY (holding register free) and HELD (one instruction latched).
REQ-013 SHALL drive iq_ready_out = (state==EMPTY) && rdy_in && !flush_in, combinationally.
REQ-014 SHALL, in EMPTY with iq_valid_in && iq_ready_out, latch inst, pc and pred bit, then go to HELD.
REQ-015 SHALL feed the latched instruction to the internal decoder continuously while in HELD.
REQ-016 SHALL route is_load_store instructions to the LSB and all others to the RS.
REQ-017 SHALL issue in HELD when !rob_full_in and the target is not full.
REQ-018 SHALL, on issue: register the decoded fields, pc and pred bit into issue_*_out; set issue_valid_out=1 and the one-hot to_lsb/to_rs bit for exactly one cycle; go to EMPTY.
REQ-019 SHALL, in HELD with the target or ROB full, remain in HELD; issue_valid_out=0; latched instruction unchanged.
REQ-020 SHALL, in HELD when decoder opt==0 (unsupported opcode or funct3), discard the instruction without issue and go to EMPTY.
REQ-021 SHALL meet latency: accept at cycle N gives earliest issue_valid_out high in cycle N+2; throughput is at most one instruction per 2 cycles.
REQ-022 SHALL give flush_in priority over everything: state to EMPTY next edge, issue_valid_out=0 next cycle, latched instruction dropped, same-cycle IQ handshake suppressed.
REQ-023 SHALL, with rdy_in low, have every register hold (including issue_valid_out); flush_in SHALL then also be ignored.
REQ-024 SHALL hold issue_* data fields at their last values when issue_valid_out=0.

Reset
REQ-025 SHALL, on rst_n_in low, asynchronously set state EMPTY and clear all issue_*_out and perf counters to 0.
REQ-026 SHALL make reset asserted mid-HELD abandon the instruction, with no issue pulse after release.

Configuration
REQ-027 SHALL use macro DISPATCH_PERF_EN; when defined, perf_issued_out counts issue pulses and perf_stall_out counts HELD cycles blocked by a full flag (rdy_in high only); both wrap modulo 2^32.
REQ-028 SHALL, without DISPATCH_PERF_EN, omit the perf ports and counters, with functionality otherwise identical.

Structure
REQ-029 SHALL keep DATA_RANGE, OPT_RANGE, opt codes and new FSM state encodings in the shared utils.v include.
REQ-030 SHALL instantiate exactly one sub-module, the existing decoder, driven by the holding register.

Verification
REQ-031 SHALL test: ADDI x1,x0,5 (0x00500093), all flags clear, accepted cycle N -> cycle N+2 issue_valid_out=1, to_rs=1, opt=ADDI, rd=1, imm=5.
REQ-032 SHALL test: SW x2,8(x1) (0x0020A423), lsb_full_in=1 for 3 cycles -> no issue while full, iq_ready_out=0; issue with to_lsb=1, imm=8, rs1=1, rs2=2 the cycle after release.
REQ-033 SHALL test: BEQ while HELD with rob_full_in=1, flush_in pulsed -> no issue, EMPTY next cycle, new instruction accepted the following cycle.
REQ-034 SHALL test: inst 0x00000000 accepted -> dropped, no issue_valid_out, EMPTY after 1 cycle in HELD.
REQ-035 SHALL test: rdy_in low 4 cycles during HELD with free resources -> outputs frozen; issue exactly once after rdy_in returns.
REQ-036 SHALL test, with DISPATCH_PERF_EN: 3 issues and 5 blocked cycles -> perf_issued_out=3, perf_stall_out=5; both 0 after reset.

Source files
------------

// File: rtl/dispatch_ctrl_pkg.sv
// dispatch_ctrl_pkg: shared widths, RV32I opcode constants, decoder opt codes
// and the dispatch FSM state encoding. Imported by dispatch_ctrl and its decoder.
package dispatch_ctrl_pkg;

  localparam int DATA_W = 32;
  localparam int OPT_W  = 7;
  localparam int REG_W  = 5;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // Opt code 0 marks an instruction the decoder does not support.
  typedef enum logic [OPT_W-1:0] {
    OPT_NONE = 7'd0,  OPT_LUI  = 7'd1,  OPT_AUIPC = 7'd2,  OPT_JAL  = 7'd3,
    OPT_JALR = 7'd4,  OPT_BEQ  = 7'd5,  OPT_BNE   = 7'd6,  OPT_BLT  = 7'd7,
    OPT_BGE  = 7'd8,  OPT_BLTU = 7'd9,  OPT_BGEU  = 7'd10, OPT_LB   = 7'd11,
    OPT_LH   = 7'd12, OPT_LW   = 7'd13, OPT_LBU   = 7'd14, OPT_LHU  = 7'd15,
    OPT_SB   = 7'd16, OPT_SH   = 7'd17, OPT_SW    = 7'd18, OPT_ADDI = 7'd19,
    OPT_SLTI = 7'd20, OPT_SLTIU = 7'd21, OPT_XORI = 7'd22, OPT_ORI  = 7'd23,
    OPT_ANDI = 7'd24, OPT_SLLI = 7'd25, OPT_SRLI  = 7'd26, OPT_SRAI = 7'd27,
    OPT_ADD  = 7'd28, OPT_SUB  = 7'd29, OPT_SLL   = 7'd30, OPT_SLT  = 7'd31,
    OPT_SLTU = 7'd32, OPT_XOR  = 7'd33, OPT_OR    = 7'd34, OPT_AND  = 7'd35,
    OPT_SRL  = 7'd36, OPT_SRA  = 7'd37
  } opt_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HELD  = 1'b1
  } state_e;

endpackage

// File: rtl/dispatch_ctrl_decoder.sv
// dispatch_ctrl_decoder: combinational RV32I decoder.
// Ports: inst_i (instruction word) -> opt_o (opt code, 0 = unsupported),
//   rd_o/rs1_o/rs2_o (raw register fields), imm_o (sign-extended immediate),
//   is_ls_o (load/store, routed to LSB), is_btype_o (conditional branch).
module dispatch_ctrl_decoder
  import dispatch_ctrl_pkg::*;
(
  input  logic [DATA_W-1:0] inst_i,
  output logic [OPT_W-1:0]  opt_o,
  output logic [REG_W-1:0]  rd_o,
  output logic [REG_W-1:0]  rs1_o,
  output logic [REG_W-1:0]  rs2_o,
  output logic [DATA_W-1:0] imm_o,
  output logic              is_ls_o,
  output logic              is_btype_o
);

  logic [2:0] f3;
  assign f3    = inst_i[14:12];
  assign rd_o  = inst_i[11:7];
  assign rs1_o = inst_i[19:15];
  assign rs2_o = inst_i[24:20];

  always_comb begin
    opt_o      = OPT_NONE;
    imm_o      = '0;
    is_ls_o    = 1'b0;
    is_btype_o = 1'b0;
    case (inst_i[6:0])
      OPC_LUI:   begin opt_o = OPT_LUI;   imm_o = {inst_i[31:12], 12'b0}; end
      OPC_AUIPC: begin opt_o = OPT_AUIPC; imm_o = {inst_i[31:12], 12'b0}; end
      OPC_JAL: begin
        opt_o = OPT_JAL;
        imm_o = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
      end
      OPC_JALR: begin
        if (f3 == 3'd0) opt_o = OPT_JALR;
        imm_o = {{20{inst_i[31]}}, inst_i[31:20]};
      end
      OPC_BRANCH: begin
        is_btype_o = 1'b1;
        imm_o = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
        case (f3)
          3'd0: opt_o = OPT_BEQ;
          3'd1: opt_o = OPT_BNE;
          3'd4: opt_o = OPT_BLT;
          3'd5: opt_o = OPT_BGE;
          3'd6: opt_o = OPT_BLTU;
          3'd7: opt_o = OPT_BGEU;
          default: opt_o = OPT_NONE;
        endcase
      end
      OPC_LOAD: begin
        is_ls_o = 1'b1;
        imm_o   = {{20{inst_i[31]}}, inst_i[31:20]};
        case (f3)
          3'd0: opt_o = OPT_LB;
          3'd1: opt_o = OPT_LH;
          3'd2: opt_o = OPT_LW;
          3'd4: opt_o = OPT_LBU;
          3'd5: opt_o = OPT_LHU;
          default: opt_o = OPT_NONE;
        endcase
      end
      OPC_STORE: begin
        is_ls_o = 1'b1;
        imm_o   = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
        case (f3)
          3'd0: opt_o = OPT_SB;
          3'd1: opt_o = OPT_SH;
          3'd2: opt_o = OPT_SW;
          default: opt_o = OPT_NONE;
        endcase
      end
      OPC_OPIMM: begin
        imm_o = {{20{inst_i[31]}}, inst_i[31:20]};
        case (f3)
          3'd0: opt_o = OPT_ADDI;
          3'd1: opt_o = OPT_SLLI;
          3'd2: opt_o = OPT_SLTI;
          3'd3: opt_o = OPT_SLTIU;
          3'd4: opt_o = OPT_XORI;
          3'd5: opt_o = inst_i[30] ? OPT_SRAI : OPT_SRLI;
          3'd6: opt_o = OPT_ORI;
          default: opt_o = OPT_ANDI;
        endcase
      end
      OPC_OP: begin
        case (f3)
          3'd0: opt_o = inst_i[30] ? OPT_SUB : OPT_ADD;
          3'd1: opt_o = OPT_SLL;
          3'd2: opt_o = OPT_SLT;
          3'd3: opt_o = OPT_SLTU;
          3'd4: opt_o = OPT_XOR;
          3'd5: opt_o = inst_i[30] ? OPT_SRA : OPT_SRL;
          3'd6: opt_o = OPT_OR;
          default: opt_o = OPT_AND;
        endcase
      end
      default: opt_o = OPT_NONE;
    endcase
  end

endmodule

// File: rtl/dispatch_ctrl.sv
// dispatch_ctrl: single-entry holding register between the instruction queue
// and the ROB/RS/LSB. Accepts one instruction, decodes it, and issues it to the
// LSB (loads/stores) or RS (everything else) once the ROB and target have room.
// Ports: clk_in, rst_n_in (async active-low), rdy_in (global freeze), flush_in;
//   iq_* instruction-queue head and iq_ready_out accept strobe;
//   rob/rs/lsb_full_in resource flags; issue_* registered issue bundle.
// Optional: DISPATCH_PERF_EN adds perf_issued_out / perf_stall_out counters.
//
// state    | meaning
// ST_EMPTY | holding register free, may accept from IQ
// ST_HELD  | one instruction latched, waiting to issue or be discarded
module dispatch_ctrl
  import dispatch_ctrl_pkg::*;
(
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              rdy_in,
  input  logic              flush_in,
  input  logic              iq_valid_in,
  input  logic [DATA_W-1:0] iq_inst_in,
  input  logic [DATA_W-1:0] iq_pc_in,
  input  logic              iq_pred_taken_in,
  output logic              iq_ready_out,
  input  logic              rob_full_in,
  input  logic              rs_full_in,
  input  logic              lsb_full_in,
  output logic              issue_valid_out,
  output logic              issue_to_lsb_out,
  output logic              issue_to_rs_out,
  output logic [OPT_W-1:0]  issue_opt_out,
  output logic [REG_W-1:0]  issue_rd_out,
  output logic [REG_W-1:0]  issue_rs1_out,
  output logic [REG_W-1:0]  issue_rs2_out,
  output logic [DATA_W-1:0] issue_imm_out,
  output logic [DATA_W-1:0] issue_pc_out,
  output logic              issue_is_btype_out,
  output logic              issue_pred_taken_out
`ifdef DISPATCH_PERF_EN
  ,
  output logic [31:0]       perf_issued_out,
  output logic [31:0]       perf_stall_out
`endif
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] inst_q, inst_d, pc_q, pc_d;
  logic              pred_q, pred_d;

  logic              valid_q, valid_d, to_lsb_q, to_lsb_d, to_rs_q, to_rs_d;
  logic [OPT_W-1:0]  opt_q, opt_d;
  logic [REG_W-1:0]  rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic [DATA_W-1:0] imm_q, imm_d, ipc_q, ipc_d;
  logic              btype_q, btype_d, ipred_q, ipred_d;

  logic [OPT_W-1:0]  dec_opt;
  logic [REG_W-1:0]  dec_rd, dec_rs1, dec_rs2;
  logic [DATA_W-1:0] dec_imm;
  logic              dec_is_ls, dec_is_btype;
  logic              blocked;

`ifdef DISPATCH_PERF_EN
  logic [31:0] perf_issued_q, perf_issued_d, perf_stall_q, perf_stall_d;
`endif

  dispatch_ctrl_decoder u_decoder (
    .inst_i     (inst_q),
    .opt_o      (dec_opt),
    .rd_o       (dec_rd),
    .rs1_o      (dec_rs1),
    .rs2_o      (dec_rs2),
    .imm_o      (dec_imm),
    .is_ls_o    (dec_is_ls),
    .is_btype_o (dec_is_btype)
  );

  assign iq_ready_out = (state_q == ST_EMPTY) && rdy_in && !flush_in;
  assign blocked      = rob_full_in || (dec_is_ls ? lsb_full_in : rs_full_in);

  always_comb begin
    state_d  = state_q;
    inst_d   = inst_q;
    pc_d     = pc_q;
    pred_d   = pred_q;
    valid_d  = valid_q;
    to_lsb_d = to_lsb_q;
    to_rs_d  = to_rs_q;
    opt_d    = opt_q;
    rd_d     = rd_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    imm_d    = imm_q;
    ipc_d    = ipc_q;
    btype_d  = btype_q;
    ipred_d  = ipred_q;
`ifdef DISPATCH_PERF_EN
    perf_issued_d = perf_issued_q;
    perf_stall_d  = perf_stall_q;
`endif
    // With rdy_in low every register, flush included, simply holds.
    if (rdy_in) begin
      valid_d  = 1'b0;
      to_lsb_d = 1'b0;
      to_rs_d  = 1'b0;
      if (flush_in) begin
        state_d = ST_EMPTY;
      end else begin
        case (state_q)
          ST_EMPTY: begin
            if (iq_valid_in) begin
              inst_d  = iq_inst_in;
              pc_d    = iq_pc_in;
              pred_d  = iq_pred_taken_in;
              state_d = ST_HELD;
            end
          end
          default: begin
            // Unsupported encodings are dropped even when resources are full.
            if (dec_opt == OPT_NONE) begin
              state_d = ST_EMPTY;
            end else if (!blocked) begin
              valid_d  = 1'b1;
              to_lsb_d = dec_is_ls;
              to_rs_d  = !dec_is_ls;
              opt_d    = dec_opt;
              rd_d     = dec_rd;
              rs1_d    = dec_rs1;
              rs2_d    = dec_rs2;
              imm_d    = dec_imm;
              ipc_d    = pc_q;
              btype_d  = dec_is_btype;
              ipred_d  = pred_q;
              state_d  = ST_EMPTY;
`ifdef DISPATCH_PERF_EN
              perf_issued_d = perf_issued_q + 32'd1;
`endif
            end else begin
`ifdef DISPATCH_PERF_EN
              perf_stall_d = perf_stall_q + 32'd1;
`endif
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q  <= ST_EMPTY;
      inst_q   <= '0;
      pc_q     <= '0;
      pred_q   <= 1'b0;
      valid_q  <= 1'b0;
      to_lsb_q <= 1'b0;
      to_rs_q  <= 1'b0;
      opt_q    <= '0;
      rd_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      imm_q    <= '0;
      ipc_q    <= '0;
      btype_q  <= 1'b0;
      ipred_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      inst_q   <= inst_d;
      pc_q     <= pc_d;
      pred_q   <= pred_d;
      valid_q  <= valid_d;
      to_lsb_q <= to_lsb_d;
      to_rs_q  <= to_rs_d;
      opt_q    <= opt_d;
      rd_q     <= rd_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      imm_q    <= imm_d;
      ipc_q    <= ipc_d;
      btype_q  <= btype_d;
      ipred_q  <= ipred_d;
    end
  end

`ifdef DISPATCH_PERF_EN
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      perf_issued_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      perf_issued_q <= perf_issued_d;
      perf_stall_q  <= perf_stall_d;
    end
  end
  assign perf_issued_out = perf_issued_q;
  assign perf_stall_out  = perf_stall_q;
`endif

  assign issue_valid_out      = valid_q;
  assign issue_to_lsb_out     = to_lsb_q;
  assign issue_to_rs_out      = to_rs_q;
  assign issue_opt_out        = opt_q;
  assign issue_rd_out         = rd_q;
  assign issue_rs1_out        = rs1_q;
  assign issue_rs2_out        = rs2_q;
  assign issue_imm_out        = imm_q;
  assign issue_pc_out         = ipc_q;
  assign issue_is_btype_out   = btype_q;
  assign issue_pred_taken_out = ipred_q;

endmodule

// File: tb/tb_dispatch_ctrl.sv
// tb_dispatch_ctrl: directed self-checking bench for dispatch_ctrl.
module tb_dispatch_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_n_in, rdy_in, flush_in;
  logic        iq_valid_in, iq_pred_taken_in, iq_ready_out;
  logic [31:0] iq_inst_in, iq_pc_in;
  logic        rob_full_in, rs_full_in, lsb_full_in;
  logic        issue_valid_out, issue_to_lsb_out, issue_to_rs_out;
  logic [6:0]  issue_opt_out;
  logic [4:0]  issue_rd_out, issue_rs1_out, issue_rs2_out;
  logic [31:0] issue_imm_out, issue_pc_out;
  logic        issue_is_btype_out, issue_pred_taken_out;
`ifdef DISPATCH_PERF_EN
  logic [31:0] perf_issued_out, perf_stall_out;
`endif

  int tests = 0;
  int fails = 0;

  localparam logic [31:0] OPT_SW = 32'd18, OPT_ADDI = 32'd19, OPT_ADD = 32'd28;

  dispatch_ctrl dut (
    .clk_in               (clk_in),
    .rst_n_in             (rst_n_in),
    .rdy_in               (rdy_in),
    .flush_in             (flush_in),
    .iq_valid_in          (iq_valid_in),
    .iq_inst_in           (iq_inst_in),
    .iq_pc_in             (iq_pc_in),
    .iq_pred_taken_in     (iq_pred_taken_in),
    .iq_ready_out         (iq_ready_out),
    .rob_full_in          (rob_full_in),
    .rs_full_in           (rs_full_in),
    .lsb_full_in          (lsb_full_in),
    .issue_valid_out      (issue_valid_out),
    .issue_to_lsb_out     (issue_to_lsb_out),
    .issue_to_rs_out      (issue_to_rs_out),
    .issue_opt_out        (issue_opt_out),
    .issue_rd_out         (issue_rd_out),
    .issue_rs1_out        (issue_rs1_out),
    .issue_rs2_out        (issue_rs2_out),
    .issue_imm_out        (issue_imm_out),
    .issue_pc_out         (issue_pc_out),
    .issue_is_btype_out   (issue_is_btype_out),
    .issue_pred_taken_out (issue_pred_taken_out)
`ifdef DISPATCH_PERF_EN
    ,
    .perf_issued_out      (perf_issued_out),
    .perf_stall_out       (perf_stall_out)
`endif
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic present(input logic [31:0] inst, input logic [31:0] pc, input logic pred);
    iq_valid_in      = 1'b1;
    iq_inst_in       = inst;
    iq_pc_in         = pc;
    iq_pred_taken_in = pred;
  endtask

  initial begin
    rst_n_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0;
    iq_valid_in = 1'b0; iq_inst_in = '0; iq_pc_in = '0; iq_pred_taken_in = 1'b0;
    rob_full_in = 1'b0; rs_full_in = 1'b0; lsb_full_in = 1'b0;

    // Reset state
    #2;
    chk("rst_valid", 32'(issue_valid_out), 32'd0);
    chk("rst_opt", 32'(issue_opt_out), 32'd0);
    chk("rst_pc", issue_pc_out, 32'd0);
    chk("rst_ready", 32'(iq_ready_out), 32'd1);
`ifdef DISPATCH_PERF_EN
    chk("rst_perf_iss", perf_issued_out, 32'd0);
    chk("rst_perf_stall", perf_stall_out, 32'd0);
`endif
    tick();
    rst_n_in = 1'b1;

    // ADDI x1,x0,5: accept in N, issue visible in N+2
    present(32'h00500093, 32'h100, 1'b0);
    #1 chk("addi_ready", 32'(iq_ready_out), 32'd1);
    tick();
    iq_valid_in = 1'b0;
    #1 chk("addi_held_ready", 32'(iq_ready_out), 32'd0);
    chk("addi_n1_valid", 32'(issue_valid_out), 32'd0);
    tick();
    chk("addi_valid", 32'(issue_valid_out), 32'd1);
    chk("addi_to_rs", 32'(issue_to_rs_out), 32'd1);
    chk("addi_to_lsb", 32'(issue_to_lsb_out), 32'd0);
    chk("addi_opt", 32'(issue_opt_out), OPT_ADDI);
    chk("addi_rd", 32'(issue_rd_out), 32'd1);
    chk("addi_imm", issue_imm_out, 32'd5);
    chk("addi_pc", issue_pc_out, 32'h100);
    tick();
    chk("addi_pulse_end", 32'(issue_valid_out), 32'd0);
    chk("addi_hold_opt", 32'(issue_opt_out), OPT_ADDI);

    // SW x2,8(x1) with LSB full for 3 held cycles
    lsb_full_in = 1'b1;
    present(32'h0020A423, 32'h200, 1'b1);
    tick();
    iq_valid_in = 1'b0;
    #1 chk("sw_full_valid", 32'(issue_valid_out), 32'd0);
    chk("sw_full_ready", 32'(iq_ready_out), 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("sw_full_valid", 32'(issue_valid_out), 32'd0);
      chk("sw_full_ready", 32'(iq_ready_out), 32'd0);
    end
    tick();
    lsb_full_in = 1'b0;
    #1 chk("sw_release_valid", 32'(issue_valid_out), 32'd0);
    tick();
    chk("sw_valid", 32'(issue_valid_out), 32'd1);
    chk("sw_to_lsb", 32'(issue_to_lsb_out), 32'd1);
    chk("sw_to_rs", 32'(issue_to_rs_out), 32'd0);
    chk("sw_opt", 32'(issue_opt_out), OPT_SW);
    chk("sw_imm", issue_imm_out, 32'd8);
    chk("sw_rs1", 32'(issue_rs1_out), 32'd1);
    chk("sw_rs2", 32'(issue_rs2_out), 32'd2);
    chk("sw_pc", issue_pc_out, 32'h200);
    chk("sw_pred", 32'(issue_pred_taken_out), 32'd1);
    tick();
    chk("sw_pulse_end", 32'(issue_valid_out), 32'd0);
    chk("sw_lsb_end", 32'(issue_to_lsb_out), 32'd0);

    // BEQ x1,x2,16 held with ROB full, then flushed; handshake in flush cycle suppressed
    rob_full_in = 1'b1;
    present(32'h00208863, 32'h300, 1'b1);
    tick();
    iq_valid_in = 1'b0;
    #1 chk("beq_held_valid", 32'(issue_valid_out), 32'd0);
    tick();
    chk("beq_held_valid", 32'(issue_valid_out), 32'd0);
    flush_in = 1'b1;
    present(32'h00700193, 32'h304, 1'b0);
    #1 chk("flush_ready", 32'(iq_ready_out), 32'd0);
    tick();
    flush_in = 1'b0;
    rob_full_in = 1'b0;
    rs_full_in = 1'b1;
    #1 chk("flush_empty_ready", 32'(iq_ready_out), 32'd1);
    chk("flush_valid", 32'(issue_valid_out), 32'd0);
    tick();
    iq_valid_in = 1'b0;
    #1 chk("after_flush_held", 32'(iq_ready_out), 32'd0);
    chk("rs_full_valid", 32'(issue_valid_out), 32'd0);
    tick();
    rs_full_in = 1'b0;
    #1 chk("rs_release_valid", 32'(issue_valid_out), 32'd0);
    tick();
    chk("addi3_valid", 32'(issue_valid_out), 32'd1);
    chk("addi3_rd", 32'(issue_rd_out), 32'd3);
    chk("addi3_imm", issue_imm_out, 32'd7);
    chk("addi3_pc", issue_pc_out, 32'h304);
    chk("addi3_btype", 32'(issue_is_btype_out), 32'd0);
`ifdef DISPATCH_PERF_EN
    chk("perf_issued", perf_issued_out, 32'd3);
    chk("perf_stall", perf_stall_out, 32'd5);
`endif

    // Unsupported instruction 0x00000000 is dropped after one HELD cycle
    present(32'h00000000, 32'h500, 1'b0);
    tick();
    iq_valid_in = 1'b0;
    #1 chk("zero_held_ready", 32'(iq_ready_out), 32'd0);
    chk("zero_held_valid", 32'(issue_valid_out), 32'd0);
    tick();
    chk("zero_no_issue", 32'(issue_valid_out), 32'd0);
    chk("zero_empty_ready", 32'(iq_ready_out), 32'd1);
    chk("zero_hold_opt", 32'(issue_opt_out), OPT_ADDI);

    // ADD x5,x1,x2 with rdy low for 4 cycles (flush pulse ignored meanwhile)
    present(32'h002082B3, 32'h600, 1'b0);
    tick();
    iq_valid_in = 1'b0;
    rdy_in = 1'b0;
    #1 chk("frz_ready", 32'(iq_ready_out), 32'd0);
    for (int i = 0; i < 4; i++) begin
      flush_in = (i == 1);
      tick();
      chk("frz_valid", 32'(issue_valid_out), 32'd0);
      chk("frz_opt", 32'(issue_opt_out), OPT_ADDI);
    end
    flush_in = 1'b0;
    rdy_in = 1'b1;
    tick();
    chk("add_valid", 32'(issue_valid_out), 32'd1);
    chk("add_opt", 32'(issue_opt_out), OPT_ADD);
    chk("add_rd", 32'(issue_rd_out), 32'd5);
    chk("add_to_rs", 32'(issue_to_rs_out), 32'd1);
    chk("add_pc", issue_pc_out, 32'h600);
    rdy_in = 1'b0;
    tick();
    chk("frz_valid_hold", 32'(issue_valid_out), 32'd1);
    rdy_in = 1'b1;
    tick();
    chk("add_once_a", 32'(issue_valid_out), 32'd0);
    tick();
    chk("add_once_b", 32'(issue_valid_out), 32'd0);

    // Reset while HELD abandons the instruction
    present(32'h00500093, 32'h700, 1'b0);
    tick();
    iq_valid_in = 1'b0;
    #1 rst_n_in = 1'b0;
    #1 chk("mid_rst_valid", 32'(issue_valid_out), 32'd0);
    chk("mid_rst_opt", 32'(issue_opt_out), 32'd0);
    chk("mid_rst_rd", 32'(issue_rd_out), 32'd0);
    chk("mid_rst_imm", issue_imm_out, 32'd0);
`ifdef DISPATCH_PERF_EN
    chk("mid_rst_perf_iss", perf_issued_out, 32'd0);
    chk("mid_rst_perf_stall", perf_stall_out, 32'd0);
`endif
    #1 rst_n_in = 1'b1;
    tick();
    chk("post_rst_valid_a", 32'(issue_valid_out), 32'd0);
    tick();
    chk("post_rst_valid_b", 32'(issue_valid_out), 32'd0);
    chk("post_rst_ready", 32'(iq_ready_out), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
